alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ALUOP_W, 4, ALUOp width (values at or above 4 zero-extend the upper bits).
  FUNCT_W, 4, funct width; bit 3 is funct7[5], bits 2:0 are funct3.
  MUL_LAT, 3, multiply latency in cycles (minimum 1).
  DIV_LAT, 33, divide/remainder latency in cycles (minimum 1).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  in_valid  in  1  decode request present.
  in_ready  out  1  block accepts the request this cycle.
  ALUOp  in  ALUOP_W  operation class from main control.
  funct  in  FUNCT_W  {funct7[5], funct3}.
  m_sel  in  1  funct7[0]; selects an RV32M op when ALUOp=0100.
  flush  in  1  discard held/in-flight op (pipeline kill).
  out_valid  out  1  ALUcntl/m_op/illegal valid.
  out_ready  in  1  EX stage consumes output.
  ALUcntl  out  4  ALU control code.
  m_op  out  3  funct3 of the M op; 000 otherwise.
  illegal  out  1  undecodable ALUOp/funct.
  busy  out  1  multicycle op counting.

Function
REQ-003 Decode SHALL be: ALUOp 0000 (load/store) -> 0110 ADD; ALUOp 0010 (branch) -> 0111 SUB.
REQ-004 ALUOp 0001 (I-type) SHALL map funct3 to: 000->0110, 001->0011 LSL, 010/011->0111, 100->0010 XOR, 110->0001 OR, 111->0000 AND, 101->0100 RSL if funct[3]=0 else 0101 RSA; funct[3] SHALL be ignored for all other funct3 values.
REQ-005 ALUOp 0100 (R-type), m_sel=0, SHALL map {funct[3],funct3} to: 0000->0110, 1000->0111, 0001->0011, 0010/0011->0111, 0100->0010, 0101->0100, 1101->0101, 0110->0001, 0111->0000; any other code SHALL be illegal.
REQ-006 Any other ALUOp SHALL yield ALUcntl=1111 and illegal=1; X SHALL never be driven.
REQ-007 Request is accepted when in_valid && in_ready; the decoded result SHALL be registered, giving out_valid one cycle after acceptance for single-cycle ops.
REQ-008 in_ready SHALL equal !busy && (!out_valid || out_ready); back-to-back single-cycle ops SHALL sustain one per cycle.
REQ-009 With out_valid=1 and out_ready=0, outputs SHALL hold stable.
REQ-010 FSM states SHALL be IDLE, MULTI and DONE: IDLE->MULTI on accepting an M op; MULTI->DONE when the counter reaches latency-1; DONE->IDLE on out_ready, or DONE->MULTI if the same-cycle accept is an M op.
REQ-011 In MULTI, busy=1 and out_valid=0; the counter SHALL load 0 on entry and count to MUL_LAT-1 (funct3 0xx) or DIV_LAT-1 (funct3 1xx).
REQ-012 M op result SHALL be ALUcntl=1000 and m_op=funct3, valid in DONE, i.e. exactly latency+1 cycles after acceptance.
REQ-013 flush SHALL clear out_valid, busy and the counter and return the FSM to IDLE next edge; flush has priority over a simultaneous accept, which is dropped.

Reset
REQ-014 On rst=1, asynchronously: state=IDLE, out_valid=0, busy=0, counter=0, ALUcntl=0000, m_op=000, illegal=0; in_ready=1 after release.
REQ-015 Reset mid-MULTI SHALL abandon the op with no output produced.

Configuration
REQ-016 Macro ALU_CTRL_RV32M_EN: when defined, REQ-010 to REQ-012 apply.
REQ-017 When not defined, ALUOp 0100 with m_sel=1 SHALL decode illegal (1111) in one cycle, no MULTI/DONE states or counter SHALL exist, and busy SHALL be tied 0.

Verification
REQ-018 ALUOp=0001, funct=1101, out_ready=1 -> next cycle ALUcntl=0101, out_valid=1, illegal=0.
REQ-019 Stream 0000/0000, 0100/0111, 0100/1000, 0100/0010 on consecutive cycles -> ALUcntl 0110, 0000, 0111, 0111 on consecutive cycles, with in_ready held high.
REQ-020 ALUOp=1111 -> ALUcntl=1111, illegal=1; ALUOp=0100, funct=1111 -> illegal=1.
REQ-021 (macro on) M op funct3=100, DIV_LAT=33 -> busy for 33 cycles, in_ready=0 throughout, out_valid on cycle 34 with ALUcntl=1000, m_op=100.
REQ-022 out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; flush asserted at cycle 10 of a divide -> out_valid stays 0 and in_ready=1 next cycle.
REQ-023 rst pulsed mid-MULTI -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with registered, handshaked output.
// Optional RV32M sequencing enabled by macro ALU_CTRL_RV32M_EN.
module alu_ctrl_seq #(
    parameter int ALUOP_W = 4,
    parameter int FUNCT_W = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               m_sel,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         ALUcntl,
    output logic [2:0]         m_op,
    output logic               illegal,
    output logic               busy
);

    localparam logic [ALUOP_W-1:0] OP_LS = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] OP_I  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] OP_BR = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] OP_R  = ALUOP_W'(4'b0100);

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_XOR = 4'b0010;
    localparam logic [3:0] C_LSL = 4'b0011;
    localparam logic [3:0] C_RSL = 4'b0100;
    localparam logic [3:0] C_RSA = 4'b0101;
    localparam logic [3:0] C_ADD = 4'b0110;
    localparam logic [3:0] C_SUB = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1000;
    localparam logic [3:0] C_BAD = 4'b1111;

    logic [2:0] f3;
    logic       f7;
    logic [3:0] dec_cntl;
    logic       dec_ill;
    logic       accept;
    logic       valid_n;
    logic [3:0] cntl_n;
    logic [2:0] mop_n;
    logic       ill_n;

    assign f3 = funct[2:0];
    assign f7 = funct[3];

`ifdef ALU_CTRL_RV32M_EN
    typedef enum logic [1:0] {
        IDLE,
        MULTI,
        DONE
    } state_t;

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_lim;
    logic             dec_m;

    // m_op holds the accepted funct3 while counting, so it picks the latency
    assign cnt_lim = m_op[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    assign busy    = (state == MULTI);
`else
    assign busy    = 1'b0;
`endif

    assign in_ready = !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Combinational decode of ALUOp/funct into an ALU control code
    always_comb begin
        dec_cntl = C_BAD;
        dec_ill  = 1'b1;
`ifdef ALU_CTRL_RV32M_EN
        dec_m    = 1'b0;
`endif
        if (ALUOp == OP_LS) begin
            dec_cntl = C_ADD;
            dec_ill  = 1'b0;
        end else if (ALUOp == OP_BR) begin
            dec_cntl = C_SUB;
            dec_ill  = 1'b0;
        end else if (ALUOp == OP_I) begin
            dec_ill = 1'b0;
            unique case (f3)
                3'b000:  dec_cntl = C_ADD;
                3'b001:  dec_cntl = C_LSL;
                3'b010:  dec_cntl = C_SUB;
                3'b011:  dec_cntl = C_SUB;
                3'b100:  dec_cntl = C_XOR;
                3'b101:  dec_cntl = f7 ? C_RSA : C_RSL;
                3'b110:  dec_cntl = C_OR;
                3'b111:  dec_cntl = C_AND;
                default: dec_cntl = C_BAD;
            endcase
        end else if (ALUOp == OP_R) begin
            if (!m_sel) begin
                dec_ill = 1'b0;
                case ({f7, f3})
                    4'b0000: dec_cntl = C_ADD;
                    4'b1000: dec_cntl = C_SUB;
                    4'b0001: dec_cntl = C_LSL;
                    4'b0010: dec_cntl = C_SUB;
                    4'b0011: dec_cntl = C_SUB;
                    4'b0100: dec_cntl = C_XOR;
                    4'b0101: dec_cntl = C_RSL;
                    4'b1101: dec_cntl = C_RSA;
                    4'b0110: dec_cntl = C_OR;
                    4'b0111: dec_cntl = C_AND;
                    default: begin
                        dec_cntl = C_BAD;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
`ifdef ALU_CTRL_RV32M_EN
            else begin
                dec_cntl = C_MUL;
                dec_ill  = 1'b0;
                dec_m    = 1'b1;
            end
`endif
        end
    end

    // Next-state and next-output selection; flush wins over everything
    always_comb begin
        valid_n = out_valid;
        cntl_n  = ALUcntl;
        mop_n   = m_op;
        ill_n   = illegal;
`ifdef ALU_CTRL_RV32M_EN
        state_n = state;
        cnt_n   = cnt;
`endif
        if (flush) begin
            valid_n = 1'b0;
`ifdef ALU_CTRL_RV32M_EN
            state_n = IDLE;
            cnt_n   = '0;
`endif
        end
`ifdef ALU_CTRL_RV32M_EN
        else if (state == MULTI) begin
            if (cnt == cnt_lim) begin
                state_n = DONE;
                valid_n = 1'b1;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
`endif
        else if (accept) begin
            valid_n = 1'b1;
            cntl_n  = dec_cntl;
            mop_n   = 3'b000;
            ill_n   = dec_ill;
`ifdef ALU_CTRL_RV32M_EN
            state_n = IDLE;
            if (dec_m) begin
                state_n = MULTI;
                cnt_n   = '0;
                valid_n = 1'b0;
                mop_n   = f3;
            end
`endif
        end else if (out_ready) begin
            valid_n = 1'b0;
`ifdef ALU_CTRL_RV32M_EN
            state_n = IDLE;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ALUcntl   <= 4'b0000;
            m_op      <= 3'b000;
            illegal   <= 1'b0;
`ifdef ALU_CTRL_RV32M_EN
            state     <= IDLE;
            cnt       <= '0;
`endif
        end else begin
            out_valid <= valid_n;
            ALUcntl   <= cntl_n;
            m_op      <= mop_n;
            illegal   <= ill_n;
`ifdef ALU_CTRL_RV32M_EN
            state     <= state_n;
            cnt       <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq.
// Define ALU_CTRL_RV32M_EN to also exercise the multicycle path.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] ALUOp = 4'b0000;
    logic [3:0] funct = 4'b0000;
    logic       m_sel = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] ALUcntl;
    logic [2:0] m_op;
    logic       illegal;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALUOp(ALUOp),
        .funct(funct),
        .m_sel(m_sel),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALUcntl(ALUcntl),
        .m_op(m_op),
        .illegal(illegal),
        .busy(busy)
    );

    // {ALUOp, funct, expected ALUcntl, expected illegal}
    logic [12:0] vecs [25] = '{
        13'b0001_1101_0101_0,
        13'b0001_0101_0100_0,
        13'b0001_1001_0011_0,
        13'b0001_0000_0110_0,
        13'b0001_0010_0111_0,
        13'b0001_0011_0111_0,
        13'b0001_1100_0010_0,
        13'b0001_0110_0001_0,
        13'b0001_0111_0000_0,
        13'b0000_0101_0110_0,
        13'b0010_0011_0111_0,
        13'b0100_0000_0110_0,
        13'b0100_1000_0111_0,
        13'b0100_0001_0011_0,
        13'b0100_0011_0111_0,
        13'b0100_0100_0010_0,
        13'b0100_0101_0100_0,
        13'b0100_1101_0101_0,
        13'b0100_0110_0001_0,
        13'b0100_0111_0000_0,
        13'b0100_1001_1111_1,
        13'b0100_1111_1111_1,
        13'b1111_0000_1111_1,
        13'b0011_0000_1111_1,
        13'b1000_0000_1111_1
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (ALUcntl !== 4'b0000 || m_op !== 3'b000 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%b exp=0000/000/0",
                     ALUcntl, m_op, illegal);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_decode();
        logic [12:0] v;
        out_ready = 1'b1;
        m_sel = 1'b0;
        for (int i = 0; i < 25; i++) begin
            v = vecs[i];
            in_valid = 1'b1;
            ALUOp = v[12:9];
            funct = v[8:5];
            tick();
            checks++;
            if (out_valid !== 1'b1 || ALUcntl !== v[4:1] ||
                illegal !== v[0] || m_op !== 3'b000) begin
                failures++;
                $display("FAIL decode_%0d op=%b fn=%b got=%b/%b/%b exp=1/%b/%b",
                         i, v[12:9], v[8:5], out_valid, ALUcntl, illegal,
                         v[4:1], v[0]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL decode_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100};
        logic [3:0] fns [4] = '{4'b0000, 4'b0111, 4'b1000, 4'b0010};
        logic [3:0] exp [4] = '{4'b0110, 4'b0000, 4'b0111, 4'b0111};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            ALUOp = ops[i];
            funct = fns[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready_%0d got=%b exp=1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || ALUcntl !== exp[i]) begin
                failures++;
                $display("FAIL b2b_%0d got=%b/%b exp=1/%b",
                         i, out_valid, ALUcntl, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        in_valid = 1'b1;
        ALUOp = 4'b0001;
        funct = 4'b0100;
        tick();
        out_ready = 1'b0;
        funct = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready_%0d got=%b exp=0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || ALUcntl !== 4'b0010 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%b/%b/%b exp=1/0010/0",
                         i, out_valid, ALUcntl, illegal);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready got=%b exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || ALUcntl !== 4'b0001) begin
            failures++;
            $display("FAIL stall_next got=%b/%b exp=1/0001", out_valid, ALUcntl);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1;
        ALUOp = 4'b0001;
        funct = 4'b0111;
        tick();
        checks++;
        if (out_valid !== 1'b1 || ALUcntl !== 4'b0000) begin
            failures++;
            $display("FAIL flush_setup got=%b/%b exp=1/0000", out_valid, ALUcntl);
        end
        ALUOp = 4'b0000;
        funct = 4'b0000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_in_ready got=%b exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        ALUOp = 4'b0001;
        funct = 4'b1101;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ALUcntl !== 4'b0101) begin
            failures++;
            $display("FAIL arst_setup got=%b/%b exp=1/0101", out_valid, ALUcntl);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ALUcntl !== 4'b0000 ||
            illegal !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_clear got=%b/%b/%b/%b exp=0/0000/0/0",
                     out_valid, ALUcntl, illegal, busy);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

`ifndef ALU_CTRL_RV32M_EN
    task automatic test_m_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1;
        ALUOp = 4'b0100;
        funct = 4'b0100;
        m_sel = 1'b1;
        tick();
        in_valid = 1'b0;
        m_sel = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ALUcntl !== 4'b1111 ||
            illegal !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL m_illegal got=%b/%b/%b/%b exp=1/1111/1/0",
                     out_valid, ALUcntl, illegal, busy);
        end
        tick();
    endtask
`else
    task automatic run_m(input logic [2:0] f3, input int lat, input string nm);
        int bad;
        bad = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        ALUOp = 4'b0100;
        funct = {1'b0, f3};
        m_sel = 1'b1;
        tick();
        in_valid = 1'b0;
        m_sel = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_busy bad_cycles=%0d exp=0", nm, bad);
        end
        checks++;
        if (out_valid !== 1'b1 || ALUcntl !== 4'b1000 ||
            m_op !== f3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done got=%b/%b/%b/%b exp=1/1000/%b/0",
                     nm, out_valid, ALUcntl, m_op, busy, f3);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_consumed got=%b exp=0", nm, out_valid);
        end
    endtask

    task automatic test_div_flush();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        ALUOp = 4'b0100;
        funct = 4'b0100;
        m_sel = 1'b1;
        tick();
        in_valid = 1'b0;
        m_sel = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL div_flush got=%b/%b/%b exp=0/0/1",
                     out_valid, busy, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL div_flush_quiet bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid_multi();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        ALUOp = 4'b0100;
        funct = 4'b0101;
        m_sel = 1'b1;
        tick();
        in_valid = 1'b0;
        m_sel = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ALUcntl !== 4'b0000 ||
            m_op !== 3'b000 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%b/%b/%b/%b exp=0/0/0000/000/0",
                     busy, out_valid, ALUcntl, m_op, illegal);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet bad_cycles=%0d exp=0", bad);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
`ifndef ALU_CTRL_RV32M_EN
        test_m_illegal();
`else
        run_m(3'b000, 3, "mul");
        run_m(3'b100, 33, "div");
        test_div_flush();
        test_reset_mid_multi();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
